// File: rtl/sreg_drain_pkg.sv
// sreg_drain_pkg: shared types and constants for the chain drain controller.
//   state_t         - drain FSM state encoding (IDLE, DRAIN, TAIL)
//   sat_hi / sat_lo - signed saturation bounds for an OUT_W-bit lane
package sreg_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TAIL  = 2'd2
  } state_t;

  // Largest value representable in a signed out_w-bit lane.
  function automatic longint sat_hi(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed out_w-bit lane.
  function automatic longint sat_lo(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/sreg_drain_rq_sat.sv
// rq_sat: one lane of round-half-up right shift followed by signed saturation.
// Purely combinational.
//   x - signed D_W-bit chain word
//   s - right-shift amount (0 passes x through before saturation)
//   y - signed OUT_W-bit saturated result
module rq_sat
  import sreg_drain_pkg::*;
#(
  parameter int D_W     = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic signed [D_W-1:0]     x,
  input  logic        [SHIFT_W-1:0] s,
  output logic signed [OUT_W-1:0]   y
);

  // One guard bit so that adding the rounding constant cannot overflow.
  localparam int W = D_W + 1;
  localparam logic signed [W-1:0] HI = W'(sat_hi(OUT_W));
  localparam logic signed [W-1:0] LO = W'(sat_lo(OUT_W));

  logic signed [W-1:0] xe;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] sh;

  always_comb begin
    xe  = {x[D_W-1], x};
    rnd = '0;
    if (s != '0) begin
      rnd = W'(1) << (s - SHIFT_W'(1));
    end
    sum = xe + rnd;
    sh  = sum >>> s;
    if (sh > HI) begin
      y = HI[OUT_W-1:0];
    end else if (sh < LO) begin
      y = LO[OUT_W-1:0];
    end else begin
      y = sh[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/sreg_drain.sv
// sreg_drain: unloads DEPTH rows from N sreg column chains, requantizes each
// lane to a saturated signed OUT_W value and emits one row per beat on a
// valid/ready stream.
//   clk, rst      - clock, asynchronous active-low reset
//   start         - begin a drain (accepted only in IDLE)
//   shift_amt     - requant shift, captured when start is accepted
//   col_data      - current head word of each chain
//   shift_en      - advances every chain by one word
//   m_valid/m_ready/m_data/m_last - output stream
//   busy          - controller not in IDLE
//   done          - one-cycle pulse after the last beat handshakes
//   state_dbg     - current FSM state
//
// Handshake: a beat transfers on any rising edge where m_valid & m_ready are
// both high; while m_valid is high and m_ready is low, m_data/m_last/m_valid
// stay constant and the chains do not advance.
module sreg_drain
  import sreg_drain_pkg::*;
#(
  parameter int D_W     = 32,
  parameter int N       = 8,
  parameter int DEPTH   = 8,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SHIFT_W-1:0]         shift_amt,
  input  logic [N-1:0][D_W-1:0]      col_data,
  output logic                       shift_en,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N-1:0][OUT_W-1:0]    m_data,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done,
  output state_t                     state_dbg
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                   state;
  logic [CW-1:0]            row_cnt;
  logic [SHIFT_W-1:0]       shift_amt_q;
  logic [N-1:0][OUT_W-1:0]  rq_data;
  logic                     last_row;
  logic                     load;
  logic                     hs;

  for (genvar g = 0; g < N; g++) begin : g_lane
    rq_sat #(
      .D_W    (D_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_rq (
      .x(col_data[g]),
      .s(shift_amt_q),
      .y(rq_data[g])
    );
  end

  assign last_row  = (row_cnt == CW'(DEPTH - 1));
  // Capture a row whenever the output register is empty or being emptied.
  assign load      = (state == DRAIN) && (!m_valid || m_ready);
  assign hs        = m_valid && m_ready;
  // Chains advance exactly when their head word is captured.
  assign shift_en  = load;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row_cnt     <= '0;
      shift_amt_q <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_amt_q <= shift_amt;
            row_cnt     <= '0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (load) begin
            m_data  <= rq_data;
            m_valid <= 1'b1;
            m_last  <= last_row;
            row_cnt <= last_row ? '0 : row_cnt + CW'(1);
            if (last_row) begin
              state <= TAIL;
            end
          end else if (hs) begin
            m_valid <= 1'b0;
          end
        end
        TAIL: begin
          // Only the final beat is left in the output register.
          if (hs) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sreg_drain.sv
// tb_sreg_drain: directed bench for sreg_drain. A behavioural chain bank
// presents rows[k] on col_data, where k counts shift_en pulses since start.
module tb_sreg_drain;
  import sreg_drain_pkg::*;

  localparam int D_W = 32, N = 8, DEPTH = 8, OUT_W = 8, SHIFT_W = 5;
  localparam int BW = N * OUT_W;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic [SHIFT_W-1:0]      shift_amt;
  logic [N-1:0][D_W-1:0]   col_data;
  logic                    shift_en;
  logic                    m_valid;
  logic                    m_ready;
  logic [N-1:0][OUT_W-1:0] m_data;
  logic                    m_last;
  logic                    busy;
  logic                    done;
  state_t                  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [D_W-1:0] rows [DEPTH][N];
  int base = 0;
  int shift_cnt = 0;
  int row_idx;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  logic          obs_last_q[$];
  int n_done, first_valid_cyc, done_cyc, stall_bad, shift_bad, busy_bad;
  int timeout, shifts, busy_after;

  sreg_drain #(
    .D_W(D_W), .N(N), .DEPTH(DEPTH), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .shift_amt(shift_amt),
    .col_data (col_data),
    .shift_en (shift_en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- chain bank model ----------------
  always @(posedge clk) begin
    if (shift_en === 1'b1) shift_cnt <= shift_cnt + 1;
  end

  always_comb begin
    row_idx = shift_cnt - base;
    for (int i = 0; i < N; i++) begin
      col_data[i] = (row_idx >= 0 && row_idx < DEPTH) ? rows[row_idx][i] : '0;
    end
  end

  // Reference requant: round half up, arithmetic shift, saturate to 8 bits.
  function automatic logic [OUT_W-1:0] ref_rq(input longint x, input int s);
    longint t;
    t = x;
    if (s > 0) t = (x + (longint'(1) <<< (s - 1))) >>> s;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t[OUT_W-1:0];
  endfunction

  // ---------------- driver / collector ----------------
  // mode 0: m_ready held high; mode 1: m_ready follows 1,0,0,1,0,1 repeating.
  // restart_at >= 0: pulse start with shift_amt=7 once that many beats are in.
  task automatic run_drain(input logic [SHIFT_W-1:0] amt, input int mode,
                           input int restart_at);
    int cyc;
    logic prev_stall;
    logic [BW-1:0] prev_data;
    logic restarted;
    logic [5:0] pat;
    pat = 6'b101001;
    obs_q.delete();
    obs_last_q.delete();
    n_done = 0; first_valid_cyc = -1; done_cyc = -1;
    stall_bad = 0; shift_bad = 0; busy_bad = 0; timeout = 0;
    prev_stall = 1'b0; prev_data = '0; restarted = 1'b0;
    @(negedge clk);
    base = shift_cnt;
    start = 1'b1;
    shift_amt = amt;
    m_ready = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      m_ready = (mode == 1) ? pat[cyc % 6] : 1'b1;
      if (restart_at >= 0 && !restarted && obs_q.size() == restart_at) begin
        start = 1'b1;
        shift_amt = 5'd7;
        restarted = 1'b1;
      end
      #1;
      if (!done && !busy) busy_bad++;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_bad++;
      if (m_valid && !m_ready && shift_en) shift_bad++;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        obs_q.push_back(m_data);
        obs_last_q.push_back(m_last);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
    if (done_cyc < 0) timeout = 1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) n_done++;
    end
    busy_after = busy;
    shifts = shift_cnt - base;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; shift_amt = '0; m_ready = 1'b1;
    for (int r = 0; r < DEPTH; r++) for (int i = 0; i < N; i++) rows[r][i] = '0;
    #2 rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [BW-1:0] e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < N; i++) begin
        rows[r][i] = 32'(16 * r + i);
        e[i*OUT_W +: OUT_W] = 8'(16 * r + i);
      end
      exp_q.push_back(e);
    end
    run_drain(5'd0, 0, -1);
    checks++; if (timeout != 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", timeout); end
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL basic_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
      checks++;
      if (obs_last_q[b] !== (b == DEPTH - 1)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", b, obs_last_q[b], b == DEPTH - 1); end
    end
    checks++; if (first_valid_cyc != 2) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want 2", first_valid_cyc); end
    checks++; if (done_cyc != DEPTH + 2) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, DEPTH + 2); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    checks++; if (shifts != DEPTH) begin errors++; $display("FAIL basic_shifts: got %0d want %0d", shifts, DEPTH); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL basic_busy: got %0d low cycles want 0", busy_bad); end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL basic_busy_after: got %0d want 0", busy_after); end
  endtask

  task automatic test_rounding();
    logic [BW-1:0] e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      rows[r][0] = 32'd24;  rows[r][1] = 32'd23;
      rows[r][2] = -32'sd24; rows[r][3] = -32'sd25;
      rows[r][4] = 32'(16 * r); rows[r][5] = 32'd8;
      rows[r][6] = -32'sd8; rows[r][7] = 32'd7;
      e = {8'd0, 8'd0, 8'd1, 8'(r), 8'hfe, 8'hff, 8'd1, 8'd2};
      exp_q.push_back(e);
    end
    run_drain(5'd4, 0, -1);
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL round_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL round_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL round_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_saturation();
    logic [BW-1:0] e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      rows[r][0] = 32'd300;  rows[r][1] = -32'sd300;
      rows[r][2] = 32'd127;  rows[r][3] = -32'sd128;
      rows[r][4] = 32'd128;  rows[r][5] = -32'sd129;
      rows[r][6] = 32'(r);   rows[r][7] = 32'h7fff_ffff;
      e = {8'h7f, 8'(r), 8'h80, 8'h7f, 8'h80, 8'h7f, 8'h80, 8'h7f};
      exp_q.push_back(e);
    end
    run_drain(5'd0, 0, -1);
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL sat_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL sat_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < N; i++) begin
        rows[r][i] = 32'(10 * r - 3 * i);
        e[i*OUT_W +: OUT_W] = 8'(10 * r - 3 * i);
      end
      exp_q.push_back(e);
    end
    run_drain(5'd0, 1, -1);
    checks++; if (timeout != 0) begin errors++; $display("FAIL bp_timeout: got %0d want 0", timeout); end
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL bp_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
      checks++;
      if (obs_last_q[b] !== (b == DEPTH - 1)) begin errors++; $display("FAIL bp_last[%0d]: got %b want %b", b, obs_last_q[b], b == DEPTH - 1); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_bad); end
    checks++; if (shift_bad != 0) begin errors++; $display("FAIL bp_shift_stall: got %0d shifts while stalled want 0", shift_bad); end
    checks++; if (shifts != DEPTH) begin errors++; $display("FAIL bp_shifts: got %0d want %0d", shifts, DEPTH); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_ignored_start();
    logic [BW-1:0] e;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < N; i++) begin
        rows[r][i] = 32'(40 * r + i - 100);
        e[i*OUT_W +: OUT_W] = ref_rq(longint'(40 * r + i - 100), 2);
      end
      exp_q.push_back(e);
    end
    run_drain(5'd2, 0, 3);
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL ign_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL ign_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", n_done); end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL ign_busy_after: got %0d want 0", busy_after); end
  endtask

  task automatic test_reset_mid_drain();
    logic [BW-1:0] e;
    for (int r = 0; r < DEPTH; r++) for (int i = 0; i < N; i++) rows[r][i] = 32'(8 * r + i + 1);
    @(negedge clk);
    base = shift_cnt; start = 1'b1; shift_amt = 5'd0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_data[0] !== 8'd33) begin
      errors++; $display("FAIL rst_mid_beat4: got valid %b lane0 %0d want 1 33", m_valid, m_data[0]);
    end
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_mid_m_data: got %h want 0", m_data); end
    checks++; if (m_last !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_last_done: got %b%b want 00", m_last, done); end
    checks++; if (busy !== 1'b0 || shift_en !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_shift: got %b%b want 00", busy, shift_en); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < N; i++) begin
        rows[r][i] = 32'(r + 2 * i);
        e[i*OUT_W +: OUT_W] = 8'(r + 2 * i);
      end
      exp_q.push_back(e);
    end
    run_drain(5'd0, 0, -1);
    checks++; if (obs_q.size() != DEPTH) begin errors++; $display("FAIL rst_mid_beats: got %0d want %0d", obs_q.size(), DEPTH); end
    for (int b = 0; b < DEPTH && b < obs_q.size(); b++) begin
      checks++;
      if (obs_q[b] !== exp_q[b]) begin errors++; $display("FAIL rst_mid_data[%0d]: got %h want %h", b, obs_q[b], exp_q[b]); end
    end
    checks++; if (shifts != DEPTH) begin errors++; $display("FAIL rst_mid_shifts: got %0d want %0d", shifts, DEPTH); end
    checks++; if (done_cyc != DEPTH + 2) begin errors++; $display("FAIL rst_mid_done_cycle: got %0d want %0d", done_cyc, DEPTH + 2); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sreg_drain.md
# sreg_drain

Drain controller that sits directly downstream of a bank of `N` `sreg` column chains at the systolic-array output. On `start`, it drives the shared `shift_en` to unload `DEPTH` rows from the chains. Each row is requantized from signed `D_W` to saturated signed `OUT_W` with rounding. Rows are emitted on a valid/ready stream with full backpressure, and the chains advance only when a row is actually captured.

## Interface
- `D_W`, 32: width of each chain word, signed.
- `N`, 8: number of column chains, i.e. lanes per output beat.
- `DEPTH`, 8: chain depth, i.e. beats per drain.
- `OUT_W`, 8: output lane width, signed; must satisfy `OUT_W < D_W`.
- `SHIFT_W`, 5: width of the requant shift; must satisfy `2**SHIFT_W <= D_W`.

Ports (direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: pulse meaning the chains hold valid results; accepted only in IDLE.
- `shift_amt` in `SHIFT_W`: requant right-shift amount, sampled when `start` is accepted.
- `col_data` in `[N-1:0][D_W-1:0]`: the `data_out` of each chain (its `mem[DEPTH-1]`).
- `shift_en` out 1: drives the `shift_en` of every chain.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream ready.
- `m_data` out `[N-1:0][OUT_W-1:0]`: requantized lanes; lane `i` comes from `col_data[i]`.
- `m_last` out 1: high on beat `DEPTH-1`.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse after the last beat handshakes.

## Operation
- **States.**
  - IDLE → DRAIN when `start` is high.
  - DRAIN → TAIL on the capture where `row_cnt == DEPTH-1`.
  - TAIL → IDLE on the handshake (`m_valid & m_ready`) of the last beat.
- **Output register.** A single-entry register holds `m_data`, `m_valid` and `m_last`.
  - `load = (state == DRAIN) & (!m_valid | m_ready)`.
  - `shift_en = load`, combinational, so exactly one chain shift happens per captured row.
- **On load:** capture `requant(col_data[i])` for all lanes, set `m_valid`, set `m_last = (row_cnt == DEPTH-1)`, and increment `row_cnt`.
- **Handshake without load** clears `m_valid`.
- **Requant per lane** for signed `x` and `s = shift_amt_q`:
  - `s == 0`: `y = x`.
  - otherwise: `y = (x + 2**(s-1)) >>> s`, computed in `D_W+1` bits so there is no overflow.
  - Saturate `y` to `[-2**(OUT_W-1), 2**(OUT_W-1)-1]`.
- **Beat order:** beat 0 is the first word presented at `col_data`, the entry that was oldest in the chain.
- **`start` while busy** is ignored, and `shift_amt_q` is unchanged.
- **`m_ready` low:** `m_data`, `m_valid` and `m_last` are held stable and `shift_en` stays 0. Data never advances past an unaccepted beat.
- **Reset (asserted low, asynchronous)**, including mid-drain:
  - state = IDLE and `row_cnt` = 0.
  - `m_valid`, `m_last`, `done`, `busy` = 0; `m_data` = 0; `shift_amt_q` = 0.
  - `shift_en` = 0.
  - The chains have no reset, so their contents are undefined; the controller must recompute before issuing a new `start`.

## Timing
- `start` sampled at edge E0 → DRAIN in the cycle after E0, with `shift_en = 1` in that cycle.
- First `m_valid` is high after E1, i.e. one cycle of latency from `start`.
- With `m_ready` held high, one beat per cycle: `DEPTH` beats on consecutive cycles and `DEPTH` `shift_en` pulses.
- `done` is high the cycle after the last handshake.
- Minimum `start`-to-`done` is `DEPTH+1` cycles; `busy` is high for that span.
- A new `start` is accepted in the cycle `done` is high, because the state is already IDLE.
- `col_data` is the registered output of the chains, so it must be valid in the cycle `shift_en` is asserted; there is no combinational path from `col_data` to `shift_en`.

## Structure
- Package `sreg_drain_pkg` holds:
  - the `state_t` enum (IDLE, DRAIN, TAIL);
  - the saturation bound constants as functions of `OUT_W`.
- Sub-module `rq_sat` holds one lane of round/shift/saturate. It is purely combinational, parameterized by `D_W`, `OUT_W`, `SHIFT_W`, and generated `N` times.
- The top level contains the FSM, `row_cnt` (`$clog2(DEPTH)` bits plus terminal compare) and the output register.

## Test plan
- **Basic drain, no backpressure.** Preload chains with lane `i`, row `r` = `16*r+i`; `shift_amt` = 0; `m_ready` = 1.
  - Expect 8 beats on consecutive cycles, values passed through unchanged in chain order.
  - `m_last` high on beat 7 only; `done` high one cycle later; exactly 8 `shift_en` pulses.
- **Rounding.** `shift_amt` = 4 with inputs 24, 23, -24, -25.
  - Expect outputs 2, 1, -1, -2.
- **Saturation.** `shift_amt` = 0 with inputs 300, -300, 127, -128.
  - Expect outputs 127, -128, 127, -128.
- **Backpressure.** Toggle `m_ready` as 1,0,0,1,0,1,….
  - `m_data` stays stable while `m_ready` is low, `shift_en` is never high while the beat is stalled, all 8 beats arrive in order, and there are exactly 8 `shift_en` pulses.
- **Ignored `start`.** Assert `start` again at beat 3 with `shift_amt` = 7 (original `shift_amt` = 2).
  - Requant stays at 2 and there is still exactly one `done`.
- **Reset mid-drain.** Assert `rst` low during beat 4.
  - All outputs go to 0 immediately. After release, a new `start` produces a full 8-beat drain.
